// File: rtl/gate_stim_pkg.sv
// Shared types for the gate stimulus/check stage: FSM states,
// res bit indices and the truth-table model with its care mask.
package gate_stim_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int RES_W      = 9;
    localparam int RES_AND    = 0;
    localparam int RES_OR     = 1;
    localparam int RES_NAND   = 2;
    localparam int RES_NOR    = 3;
    localparam int RES_XOR    = 4;
    localparam int RES_XNOR   = 5;
    localparam int RES_INV    = 6;
    localparam int RES_BUF    = 7;
    localparam int RES_NOTIF1 = 8;

    typedef struct packed {
        logic [RES_W-1:0] val;
        logic [RES_W-1:0] care;
    } exp_t;

    function automatic exp_t exp_res(
        input logic enable,
        input logic in1,
        input logic in2
    );
        exp_t e;
        e.val  = '0;
        e.care = '1;
        e.val[RES_AND]    = in1 & in2;
        e.val[RES_OR]     = in1 | in2;
        e.val[RES_NAND]   = ~(in1 & in2);
        e.val[RES_NOR]    = ~(in1 | in2);
        e.val[RES_XOR]    = in1 ^ in2;
        e.val[RES_XNOR]   = ~(in1 ^ in2);
        e.val[RES_INV]    = ~in1;
        e.val[RES_BUF]    = in1;
        e.val[RES_NOTIF1] = ~in1;
        // notif1 floats while disabled, so its value carries no meaning
        e.care[RES_NOTIF1] = enable;
        return e;
    endfunction

endpackage

// File: rtl/gate_stim_check_if.sv
// Stimulus/response bundle between the check stage and the gate cell.
// master drives stimulus and reads results; slave is the gate side.
interface gate_stim_check_if;
    import gate_stim_pkg::*;

    logic             in1;
    logic             in2;
    logic             enable;
    logic [RES_W-1:0] res;

    modport master (
        output in1,
        output in2,
        output enable,
        input  res
    );

    modport slave (
        input  in1,
        input  in2,
        input  enable,
        output res
    );

endinterface

// File: rtl/gate_stim_check_truth_cmp.sv
// Combinational compare of the gate outputs against the truth table.
// Any unknown value on a cared-for bit is reported as a mismatch.
module gate_truth_cmp
    import gate_stim_pkg::*;
(
    input  logic             enable,
    input  logic             in1,
    input  logic             in2,
    input  logic [RES_W-1:0] res,
    output logic             mismatch
);

    exp_t             e;
    logic [RES_W-1:0] diff;

    assign e        = exp_res(enable, in1, in2);
    assign diff     = (res ^ e.val) & e.care;
    assign mismatch = (diff !== '0);

endmodule

// File: rtl/gate_stim_check.sv
// Clocked sweep of all 8 gate vectors with settle, compare and error count.
// Optional first-failure log: define GATE_STIM_CHECK_ERRLOG_EN.
module gate_stim_check
    import gate_stim_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int LOOPS       = 1,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    gate_stim_check_if.master gate,
    output logic [2:0]       vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef GATE_STIM_CHECK_ERRLOG_EN
    output logic [2:0]       first_fail_vec,
    output logic [RES_W-1:0] first_fail_res,
    output logic             first_fail_valid,
`endif
    output logic [ERR_W-1:0] err_count
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [3:0] loop;
    logic       in1_q;
    logic       in2_q;
    logic       en_q;
    logic       mismatch;
    logic       last_vec;
    logic       last_loop;
    logic       accept;

    assign gate.in1    = in1_q;
    assign gate.in2    = in2_q;
    assign gate.enable = en_q;

    assign last_vec  = (vec_idx == 3'd7);
    assign last_loop = (loop == 4'(LOOPS - 1));
    assign accept    = start &&
                       ((state == S_IDLE) || (state == S_DONE));

    gate_truth_cmp u_cmp (
        .enable   (en_q),
        .in1      (in1_q),
        .in2      (in2_q),
        .res      (gate.res),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE,
            S_DONE:   if (accept) state_nxt = S_DRIVE;
            S_DRIVE:  state_nxt = S_SETTLE;
            S_SETTLE: if (cnt == 8'd0) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (last_vec && last_loop) ?
                                  S_DONE : S_DRIVE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_DRIVE) || (state == S_SETTLE) ||
               (state == S_CHECK);
        done = (state == S_DONE);
        pass = done && (err_count == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_idx   <= '0;
            cnt       <= '0;
            loop      <= '0;
            in1_q     <= 1'b0;
            in2_q     <= 1'b0;
            en_q      <= 1'b0;
            err_count <= '0;
        end else begin
            unique case (state)
                S_IDLE,
                S_DONE: begin
                    if (accept) begin
                        vec_idx   <= '0;
                        loop      <= '0;
                        err_count <= '0;
                    end
                end
                S_DRIVE: begin
                    {en_q, in1_q, in2_q} <= vec_idx;
                    cnt <= 8'(HOLD_CYCLES - 1);
                end
                S_SETTLE: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                S_CHECK: begin
                    if (mismatch && (err_count != '1))
                        err_count <= err_count + 1'b1;
                    if (!last_vec) begin
                        vec_idx <= vec_idx + 3'd1;
                    end else if (!last_loop) begin
                        vec_idx <= '0;
                        loop    <= loop + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_STIM_CHECK_ERRLOG_EN
    // only the first failing vector of a run is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail_vec   <= '0;
            first_fail_res   <= '0;
            first_fail_valid <= 1'b0;
        end else if (accept) begin
            first_fail_vec   <= '0;
            first_fail_res   <= '0;
            first_fail_valid <= 1'b0;
        end else if ((state == S_CHECK) && mismatch &&
                     !first_fail_valid) begin
            first_fail_vec   <= vec_idx;
            first_fail_res   <= gate.res;
            first_fail_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gate_stim_check.sv
// Directed bench for gate_stim_check: good gate model plus injected faults,
// reset mid-run, start spamming and a saturating narrow counter.
module tb_gate_stim_check;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [2:0] mode = 3'd0;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    gate_stim_check_if if0 ();
    gate_stim_check_if if1 ();

    logic [2:0] vec_idx0, vec_idx1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [7:0] err0;
    logic [1:0] err1;
`ifdef GATE_STIM_CHECK_ERRLOG_EN
    logic [2:0] ffv0, ffv1;
    logic [8:0] ffr0, ffr1;
    logic       ffok0, ffok1;
`endif

    gate_stim_check dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gate      (if0),
        .vec_idx   (vec_idx0),
        .busy      (busy0),
        .done      (done0),
        .pass      (pass0),
`ifdef GATE_STIM_CHECK_ERRLOG_EN
        .first_fail_vec   (ffv0),
        .first_fail_res   (ffr0),
        .first_fail_valid (ffok0),
`endif
        .err_count (err0)
    );

    gate_stim_check #(
        .HOLD_CYCLES (4),
        .LOOPS       (2),
        .ERR_W       (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .gate      (if1),
        .vec_idx   (vec_idx1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
`ifdef GATE_STIM_CHECK_ERRLOG_EN
        .first_fail_vec   (ffv1),
        .first_fail_res   (ffr1),
        .first_fail_valid (ffok1),
`endif
        .err_count (err1)
    );

    function automatic logic [8:0] model(input logic a, input logic b);
        logic [8:0] r;
        r[0] = a & b;
        r[1] = a | b;
        r[2] = ~(a & b);
        r[3] = ~(a | b);
        r[4] = a ^ b;
        r[5] = ~(a ^ b);
        r[6] = ~a;
        r[7] = a;
        r[8] = ~a;
        return r;
    endfunction

    // mode: 0 good, 1 xor stuck 0, 2 notif1 wrong while disabled,
    // 3 all bits inverted, 4 notif1 always inverted
    logic [8:0] r0;
    always_comb begin
        r0 = model(if0.in1, if0.in2);
        case (mode)
            3'd1: r0[4] = 1'b0;
            3'd2: if (!if0.enable) r0[8] = ~r0[8];
            3'd3: r0 = ~r0;
            3'd4: r0[8] = ~r0[8];
            default: ;
        endcase
    end
    assign if0.res = r0;
    assign if1.res = ~model(if1.in1, if1.in2);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run0(input bit spam, input bit sweep,
                        output int cyc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = spam;
        cyc = 0;
        while (!done0 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (sweep && (cyc % 6 == 2) && cyc < 48) begin
                chk("sweep_stim", {29'd0, if0.enable, if0.in1, if0.in2},
                    (cyc - 2) / 6);
                chk("sweep_idx", {29'd0, vec_idx0}, (cyc - 2) / 6);
                chk("sweep_busy", {31'd0, busy0}, 1);
            end
            if (done0) start = 1'b0;
        end
        start = 1'b0;
        chk("done_reached", {31'd0, done0}, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {if0.in1, if0.in2, if0.enable, vec_idx0,
                           busy0, done0, pass0, err0}, 0);
        rst = 1'b0;

        // good gate, sweep and latency
        mode = 3'd0;
        run0(1'b0, 1'b1, n);
        chk("good_cycles", n, 48);
        chk("good_pass", {31'd0, pass0}, 1);
        chk("good_err", {24'd0, err0}, 0);
        chk("good_stim_hold", {29'd0, if0.enable, if0.in1, if0.in2}, 7);
        chk("good_busy_off", {31'd0, busy0}, 0);
`ifdef GATE_STIM_CHECK_ERRLOG_EN
        chk("good_ff_valid", {31'd0, ffok0}, 0);
`endif

        // xor stuck at 0
        mode = 3'd1;
        run0(1'b0, 1'b0, n);
        chk("xor_pass", {31'd0, pass0}, 0);
        chk("xor_err", {24'd0, err0}, 4);
`ifdef GATE_STIM_CHECK_ERRLOG_EN
        chk("xor_ff_valid", {31'd0, ffok0}, 1);
        chk("xor_ff_vec", {29'd0, ffv0}, 1);
        chk("xor_ff_res", {23'd0, ffr0}, 32'h146);
`endif

        // notif1 garbage while disabled must be masked
        mode = 3'd2;
        run0(1'b0, 1'b0, n);
        chk("mask_pass", {31'd0, pass0}, 1);
        chk("mask_err", {24'd0, err0}, 0);

        // notif1 wrong while enabled must be caught
        mode = 3'd4;
        run0(1'b0, 1'b0, n);
        chk("notif_err", {24'd0, err0}, 4);
`ifdef GATE_STIM_CHECK_ERRLOG_EN
        chk("notif_ff_vec", {29'd0, ffv0}, 4);
`endif

        // start spammed during the run
        mode = 3'd0;
        run0(1'b1, 1'b0, n);
        chk("spam_cycles", n, 48);
        chk("spam_pass", {31'd0, pass0}, 1);
        @(posedge clk); #1;
        chk("spam_done_held", {31'd0, done0}, 1);

        // reset during SETTLE of vector 5
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        chk("rst_pre_stim", {29'd0, if0.enable, if0.in1, if0.in2}, 5);
        chk("rst_pre_busy", {31'd0, busy0}, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outs", {if0.in1, if0.in2, if0.enable, vec_idx0,
                               busy0, done0, pass0, err0}, 0);
        #1 rst = 1'b0;
        run0(1'b0, 1'b1, n);
        chk("rerun_cycles", n, 48);
        chk("rerun_pass", {31'd0, pass0}, 1);

        // narrow counter saturates across two loops
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        n = 0;
        while (!done1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sat_done", {31'd0, done1}, 1);
        chk("sat_cycles", n, 96);
        chk("sat_err", {30'd0, err1}, 3);
        chk("sat_pass", {31'd0, pass1}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
